// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared definitions for the instruction-memory boot loader.
//   state_t        - loader FSM states (3-bit encoding)
//   HDR_W          - width of the big-endian word-count header
//   BYTES_PER_WORD - stream bytes per instruction word
package im_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_PAYLOAD,
        ST_CHECK,
        ST_ZFILL,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int unsigned HDR_W          = 16;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: collects stream bytes into little-endian words.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   clear_i       - restart packing at byte 0 (new frame)
//   byte_valid_i  - a payload byte is accepted this cycle
//   byte_i        - the accepted byte
//   word_o        - assembled word, meaningful when word_valid_o = 1
//   word_valid_o  - this cycle's byte completes a word
import im_loader_pkg::*;

module byte_word_packer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
);

    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;

    // Bytes enter at the top and shift down, so the first byte of a word
    // ends in [7:0]. The completed word is presented combinationally on
    // the 4th byte; the top registers it into the write port.
    always_comb begin
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        word_valid_o = 1'b0;
        word_o       = {byte_i, sh_q[DATA_W-1:8]};
        if (clear_i) begin
            cnt_d = '0;
        end else if (byte_valid_i) begin
            sh_d         = word_o;
            cnt_d        = cnt_q + 2'd1;
            word_valid_o = (cnt_q == 2'(BYTES_PER_WORD - 1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/im_loader.sv
// im_loader: boot-time writer for the instruction memory. Parses a framed
// byte stream (16-bit BE word count, N LE words, XOR checksum byte), writes
// the words, zero-fills the rest of memory and holds the CPU in reset
// while doing so.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   start               - begin a load (honoured in IDLE/DONE/ERR only)
//   in_valid, in_data   - byte stream in; in_ready - loader accepts byte
//   wr_en, wr_addr,     - instruction memory write port (byte address,
//   wr_data               word aligned)
//   cpu_hold            - hold processor in reset
//   done, error         - load succeeded / header or checksum failure
import im_loader_pkg::*;

module im_loader #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [31:0]       wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned IDX_W = $clog2(DEPTH + 1);

    state_t             state_q, state_d;
    logic [HDR_W-1:0]   n_q, n_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         csum_q, csum_d;

    logic               in_ready_q, in_ready_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               accept;
    logic               start_ok;
    logic [HDR_W-1:0]   n_full;
    logic [HDR_W-1:0]   idx_ext;
    logic [DATA_W-1:0]  pk_word;
    logic               pk_valid;

    assign accept   = in_valid && in_ready_q;
    assign start_ok = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign n_full   = {n_q[HDR_W-1:8], in_data};
    assign idx_ext  = HDR_W'(idx_q);

    byte_word_packer #(.DATA_W(DATA_W)) u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (start_ok),
        .byte_valid_i (accept && (state_q == ST_PAYLOAD)),
        .byte_i       (in_data),
        .word_o       (pk_word),
        .word_valid_o (pk_valid)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR_HI;
                    n_d     = '0;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end
            ST_HDR_HI: begin
                if (accept) begin
                    n_d[HDR_W-1:8] = in_data;
                    csum_d         = csum_q ^ in_data;
                    state_d        = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (accept) begin
                    n_d    = n_full;
                    csum_d = csum_q ^ in_data;
                    if (n_full > HDR_W'(DEPTH))
                        state_d = ST_ERR;
                    else if (n_full == '0)
                        state_d = ST_CHECK;
                    else
                        state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    csum_d = csum_q ^ in_data;
                    if (pk_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = 32'(idx_q) << 2;
                        wr_data_d = pk_word;
                        idx_d     = idx_q + IDX_W'(1);
                        if (idx_ext + HDR_W'(1) == n_q)
                            state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (in_data != csum_q)
                        state_d = ST_ERR;
                    else if (idx_ext == HDR_W'(DEPTH))
                        state_d = ST_DONE;
                    else
                        state_d = ST_ZFILL;
                end
            end
            ST_ZFILL: begin
                // One zero write per cycle; the extra cycle after the last
                // write lets done rise one cycle after that write.
                if (idx_ext < HDR_W'(DEPTH)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = 32'(idx_q) << 2;
                    wr_data_d = '0;
                    idx_d     = idx_q + IDX_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered copies of the next state.
        in_ready_d = state_d inside {ST_HDR_HI, ST_HDR_LO, ST_PAYLOAD, ST_CHECK};
        cpu_hold_d = !(state_d inside {ST_IDLE, ST_DONE});
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: self-checking bench for im_loader. A frame-level model
// builds each byte stream and the list of memory writes it must produce;
// a monitor compares every wr_en cycle against that list.
module tb_im_loader;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, wr_en, cpu_hold, done, error;
    logic [31:0] wr_addr, wr_data;

    im_loader #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    int          nwrites = 0;
    logic [31:0] first_data = '0;
    logic [7:0]  last_cs = '0;
    logic        wr_prev = 1'b0;
    logic        done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Write monitor: every strobe must match the next modelled write.
    always @(negedge clk) begin
        if (!reset_n) begin
            wr_prev   = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (wr_en) begin
                if (nwrites == 0) first_data = wr_data;
                nwrites++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual addr=%h data=%h required=no write", wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e.a);
                    chk("wr_data", wr_data, e.d);
                end
                chk("hold_during_write", {31'd0, cpu_hold}, 32'd1);
                chk("done_during_write", {31'd0, done}, 32'd0);
            end
            if (done && !done_prev)
                chk("done_after_last_write", {31'd0, wr_prev}, 32'd1);
            wr_prev   = wr_en;
            done_prev = done;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
        chk({tag, "_wr_addr"},  wr_addr,           32'd0);
        chk({tag, "_wr_data"},  wr_data,           32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_error"},    {31'd0, error},    32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive one byte after `gap` idle cycles; optionally pulse start in the gap.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
        int budget;
        budget = 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = pulse && (g == 0);
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready) begin
            budget++;
            if (budget > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=in_ready low required=byte %h accepted", b);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int i, input logic [31:0] w0, input logic [31:0] w1);
        return (i == 0) ? w0 : w1;
    endfunction

    // Build a frame, the writes it must cause, run it and check the end state.
    task automatic run_load(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input bit corrupt, input int max_gap, input int start_at);
        logic [7:0]  fb[$];
        logic [7:0]  cs;
        logic [31:0] w;
        bit          hdr_ok, good;
        int          budget;
        int          gap;

        exp_q.delete();
        nwrites = 0;
        fb.push_back(n[15:8]);
        fb.push_back(n[7:0]);
        hdr_ok = (n <= DEPTH);
        good   = hdr_ok && !corrupt;
        if (hdr_ok) begin
            for (int i = 0; i < n; i++) begin
                w = word_of(i, w0, w1);
                for (int k = 0; k < 4; k++) fb.push_back(w[8*k +: 8]);
                exp_q.push_back('{a: 32'(i * 4), d: w});
            end
            cs = 8'h00;
            foreach (fb[k]) cs = cs ^ fb[k];
            last_cs = cs;
            fb.push_back(corrupt ? (cs ^ 8'h03) : cs);
            if (!corrupt)
                for (int i = n; i < DEPTH; i++) exp_q.push_back('{a: 32'(i * 4), d: 32'd0});
        end

        pulse_start();
        chk("cpu_hold_after_start", {31'd0, cpu_hold}, 32'd1);
        chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
        chk("done_cleared",         {31'd0, done},     32'd0);
        chk("error_cleared",        {31'd0, error},    32'd0);

        foreach (fb[k]) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (k == start_at && gap == 0) gap = 1;
            send_byte(fb[k], gap, k == start_at);
        end
        if (!hdr_ok)
            chk("err_on_header_edge", {31'd0, error}, 32'd1);

        budget = 0;
        while (!(done || error) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (!(done || error)) begin
            checks++;
            failures++;
            $display("FAIL completion_timeout actual=no done/error required=finish within 500 cycles");
        end
        repeat (4) @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        chk("done_final",     {31'd0, done},     {31'd0, good});
        chk("error_final",    {31'd0, error},    {31'd0, !good});
        chk("hold_final",     {31'd0, cpu_hold}, {31'd0, !good});
        chk("in_ready_final", {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // N=1 good frame: 00 01 16 00 90 E2 65
        run_load(1, 32'hE2900016, 32'h0, 1'b0, 0, -1);
        chk("t1_checksum_pin", {24'd0, last_cs}, 32'h65);
        chk("t1_first_data",   first_data, 32'hE2900016);
        chk("t1_writes",       32'(nwrites), 32'd64);

        // Same frame, checksum 66
        run_load(1, 32'hE2900016, 32'h0, 1'b1, 0, -1);
        chk("t2_writes",     32'(nwrites), 32'd1);
        chk("t2_first_data", first_data, 32'hE2900016);

        // N=65 > DEPTH
        run_load(65, 32'h0, 32'h0, 1'b0, 0, -1);
        chk("t3_writes", 32'(nwrites), 32'd0);

        // N=0: pure zero fill
        run_load(0, 32'h0, 32'h0, 1'b0, 0, -1);
        chk("t4_checksum_pin", {24'd0, last_cs}, 32'h00);
        chk("t4_writes",       32'(nwrites), 32'd64);

        // N=2 with random stalls and a start pulse mid-payload
        run_load(2, 32'h11223344, 32'hA5A55A5A, 1'b0, 3, 4);
        chk("t5_first_data", first_data, 32'h11223344);
        chk("t5_writes",     32'(nwrites), 32'd64);

        // Reset mid-payload, then a fresh load
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        send_byte(8'hCC, 0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        run_load(1, 32'hDEADBEEF, 32'h0, 1'b0, 1, -1);
        chk("t6_first_data", first_data, 32'hDEADBEEF);
        chk("t6_writes",     32'(nwrites), 32'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=still running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time writer for the instruction memory: accepts a framed byte stream over a valid/ready handshake, assembles 32-bit instruction words, and drives the instruction memory's write port. It holds the processor in reset while loading, verifies an XOR checksum, and zero-fills every word past the loaded program. It sits between the host/serial front end and the instruction memory, opposite the processor's read port.

## Interface
- `DEPTH`, default 64: instruction memory depth in words; word index range 0..DEPTH-1.
- `DATA_W`, default 32: instruction word width; fixed at 4 bytes.

- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERR.
- `in_valid` input 1: byte available.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts the byte; transfer occurs on an edge where `in_valid && in_ready`.
- `wr_en` output 1: instruction memory write strobe, one cycle per word.
- `wr_addr` output 32: byte address, word-aligned (`index << 2`), bits [1:0] always 0.
- `wr_data` output 32: word to write.
- `cpu_hold` output 1: holds the processor in reset.
- `done` output 1: level; load completed successfully.
- `error` output 1: level; header or checksum failure.

## Operation
- Frame: N_hi, N_lo (16-bit word count, big-endian), then N words of 4 bytes each, little-endian (first byte is [7:0]), then 1 checksum byte.
- Checksum: XOR of every byte before it, header included. A running XOR register resets on `start`.
- FSM states: IDLE, HDR_HI, HDR_LO, PAYLOAD, CHECK, ZFILL, DONE, ERR.
  - IDLE/DONE/ERR --start--> HDR_HI. `start` clears `done`, `error` and the checksum, and sets `cpu_hold`.
  - HDR_HI --byte--> HDR_LO.
  - HDR_LO --byte--> ERR if N > DEPTH; CHECK if N = 0; otherwise PAYLOAD.
  - PAYLOAD: a byte counter of 0..3 fills a shift register. On the 4th byte the word is written at the current index and the index increments. After word N-1 the FSM goes to CHECK.
  - CHECK --byte--> ZFILL if the byte equals the running XOR; otherwise ERR.
  - ZFILL: writes 0 to indices N..DEPTH-1, one per cycle, then goes to DONE. If N = DEPTH it goes straight to DONE.
  - DONE: `done`=1 and `cpu_hold`=0.
  - ERR: `error`=1, `cpu_hold` stays 1, and no further writes occur.
- `in_ready`=1 only in HDR_HI, HDR_LO, PAYLOAD and CHECK. Bytes are never dropped or duplicated. Stalls of `in_valid` of any length are legal.
- Words already written before an ERR are not rolled back.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=0, `done`=0, `error`=0, state IDLE. Outputs take these values asynchronously on the falling edge of `reset_n`.
- All outputs are registered.
- `cpu_hold` rises in the cycle after the `start` edge.
- `wr_en` pulses in the cycle after the edge that accepts a word's 4th byte. `wr_addr`/`wr_data` are valid only while `wr_en`=1.
- ZFILL issues back-to-back `wr_en` pulses, one per cycle, for DEPTH-N cycles. `done` rises in the cycle after the last zero write.
- Minimum load time is 2 + 4N + 1 accepted bytes, plus DEPTH-N fill cycles.
- `start` while busy (HDR_HI..ZFILL) is ignored.
- Reset mid-operation aborts immediately to IDLE with `cpu_hold`=0. Partial memory contents remain.
- N > DEPTH: ERR is entered on the HDR_LO accept edge and no `wr_en` is issued.

## Structure
- Shared package `im_loader_pkg` holds:
  - the state enum (8 states, 3 bits);
  - header width (16);
  - bytes per word (4).
- One sub-module: `byte_word_packer`. It owns the 2-bit byte counter and the little-endian shift register, and outputs `word`/`word_valid`. The top-level module holds the FSM, word index, XOR, and write-port registers.

## Test plan
- N=1, bytes 00 01 16 00 90 E2, checksum 65 -> one write of addr 0x0, data 0xE2900016; then 63 zero writes to addr 0x4..0xFC; `done`=1, `cpu_hold`=0.
- Same frame with checksum 66 -> the 0xE2900016 write occurs, then `error`=1, `cpu_hold`=1, and there are no zero-fill writes.
- Header 00 41 (N=65 > DEPTH) -> ERR on the header accept edge, zero `wr_en` pulses.
- N=0, bytes 00 00, checksum 00 -> 64 zero writes at 0x0..0xFC, then `done`.
- N=2 with random `in_valid` gaps, plus a `start` pulse mid-payload -> exactly two correct writes at 0x0/0x4; the extra `start` is ignored.
- Deassert `reset_n` mid-PAYLOAD -> outputs take their reset values immediately. A fresh `start` and frame then loads correctly.
